// File: rtl/bcd_conv_arbiter.sv
// bcd_conv_arbiter: one shared double-dabble binary-to-BCD engine serving
// two requesters (player A / player B operands). A request is granted in
// IDLE, the operand is converted over WIDTH shift cycles, and the result is
// written to the requester's BCD register together with a one-cycle ack.
// Optional feature macro: BCD_ARB_RR_EN
//   defined   -> round-robin arbitration between simultaneous requests
//   undefined -> fixed priority, requester A wins
module bcd_conv_arbiter #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  ClkPort,
  input  logic                  Reset,
  input  logic                  reqA,
  input  logic [WIDTH-1:0]      binA,
  output logic                  ackA,
  output logic [4*DIGITS-1:0]   bcdA,
  input  logic                  reqB,
  input  logic [WIDTH-1:0]      binB,
  output logic                  ackB,
  output logic [4*DIGITS-1:0]   bcdB,
  output logic                  busy,
  output logic                  grant
);

  localparam int BCDW = 4 * DIGITS;
  localparam int CNTW = $clog2(WIDTH + 1);
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t              state;
  logic [WIDTH-1:0]    shift_reg;
  logic [BCDW-1:0]     digits;
  logic [CNTW-1:0]     iter_cnt;

  logic                elig_a;
  logic                elig_b;
  logic                pick_b;
  logic [BCDW-1:0]     digits_adj;
  logic [BCDW-1:0]     digits_next;
  logic [WIDTH-1:0]    shift_next;

  // A requester is only eligible when it is not in its own ack cycle, so the
  // just-served side cannot be re-granted before it sees the acknowledge.
  assign elig_a = reqA & ~ackA;
  assign elig_b = reqB & ~ackB;

`ifdef BCD_ARB_RR_EN
  // Last-served pointer: 1 = B, 0 = A. Starts at B so A wins the first tie.
  logic last_served;

  assign pick_b = elig_b & (~elig_a | ~last_served);

  // Record which side was granted each time a new conversion starts.
  always_ff @(posedge ClkPort or posedge Reset) begin
    if (Reset) begin
      last_served <= 1'b1;
    end else if (state == IDLE && (elig_a || elig_b)) begin
      last_served <= pick_b;
    end
  end
`else
  assign pick_b = elig_b & ~elig_a;
`endif

  // Add-3 correction: every digit above 4 gets +3 before the shift so the
  // following doubling carries correctly into the next decimal digit.
  always_comb begin
    digits_adj = digits;
    for (int i = 0; i < DIGITS; i++) begin
      if (digits[4*i +: 4] > 4'd4) begin
        digits_adj[4*i +: 4] = digits[4*i +: 4] + 4'd3;
      end
    end
  end

  // One double-dabble step: the corrected digits and the binary operand
  // shift left together; the operand MSB enters digit 0.
  assign {digits_next, shift_next} = {digits_adj, shift_reg} << 1;

  assign busy = (state != IDLE);

  // Main FSM: grant in IDLE, WIDTH shift iterations, then publish the result
  // and pulse the ack of the granted requester.
  always_ff @(posedge ClkPort or posedge Reset) begin
    if (Reset) begin
      state     <= IDLE;
      shift_reg <= '0;
      digits    <= '0;
      iter_cnt  <= '0;
      grant     <= 1'b0;
      ackA      <= 1'b0;
      ackB      <= 1'b0;
      bcdA      <= '0;
      bcdB      <= '0;
    end else begin
      ackA <= 1'b0;
      ackB <= 1'b0;
      case (state)
        IDLE: begin
          if (elig_a || elig_b) begin
            grant     <= pick_b;
            shift_reg <= pick_b ? binB : binA;
            digits    <= '0;
            iter_cnt  <= '0;
            state     <= SHIFT;
          end
        end
        SHIFT: begin
          digits    <= digits_next;
          shift_reg <= shift_next;
          iter_cnt  <= iter_cnt + 1'b1;
          if (iter_cnt == CNT_LAST) begin
            state <= DONE;
          end
        end
        DONE: begin
          if (grant) begin
            bcdB <= digits;
            ackB <= 1'b1;
          end else begin
            bcdA <= digits;
            ackA <= 1'b1;
          end
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_conv_arbiter.sv
// tb_bcd_conv_arbiter: directed stimulus with a scoreboard queue of expected
// results; a monitor pops and compares whenever an ack is presented.
module tb_bcd_conv_arbiter;

  logic        ClkPort = 1'b0;
  logic        Reset;
  logic        reqA;
  logic [7:0]  binA;
  logic        ackA;
  logic [11:0] bcdA;
  logic        reqB;
  logic [7:0]  binB;
  logic        ackB;
  logic [11:0] bcdB;
  logic        busy;
  logic        grant;

  typedef struct packed {
    logic        is_b;
    logic [11:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_cmp    = 0;
  int   n_fail   = 0;
  int   ack_seen = 0;
  logic prev_a   = 1'b0;
  logic prev_b   = 1'b0;

  bcd_conv_arbiter #(.WIDTH(8), .DIGITS(3)) dut (
    .ClkPort (ClkPort),
    .Reset   (Reset),
    .reqA    (reqA),
    .binA    (binA),
    .ackA    (ackA),
    .bcdA    (bcdA),
    .reqB    (reqB),
    .binB    (binB),
    .ackB    (ackB),
    .bcdB    (bcdB),
    .busy    (busy),
    .grant   (grant)
  );

  always #5 ClkPort = ~ClkPort;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic a_req, input logic [7:0] a_bin,
                               input logic b_req, input logic [7:0] b_bin);
    reqA = a_req;
    binA = a_bin;
    reqB = b_req;
    binB = b_bin;
  endtask

  task automatic pushExp(input logic is_b, input logic [11:0] val);
    exp_t e;
    e.is_b = is_b;
    e.val  = val;
    sb.push_back(e);
  endtask

  task automatic waitAcks(input int n, input int budget, input string name);
    int target;
    int cyc;
    target = ack_seen + n;
    cyc = 0;
    while (ack_seen < target && cyc < budget) begin
      @(negedge ClkPort);
      #1;
      cyc++;
    end
    if (ack_seen < target) begin
      n_cmp++;
      n_fail++;
      $display("[TB] FAIL %s_timeout: got %0d acks expected %0d", name, ack_seen - (target - n), n);
    end
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge ClkPort);
      #1;
    end
  endtask

  task automatic measureLatency(input string name, input int exp_lat, input int exp_busy);
    int  cyc;
    int  busy_cnt;
    logic got;
    cyc = 0;
    busy_cnt = 0;
    got = 1'b0;
    while (!got && cyc < 20) begin
      @(negedge ClkPort);
      #1;
      cyc++;
      if (busy) busy_cnt++;
      if (ackA) got = 1'b1;
    end
    checkOutput({name, "_latency"}, cyc, exp_lat);
    checkOutput({name, "_busy_cycles"}, busy_cnt, exp_busy);
  endtask

  // Monitor: every ack must match the next scoreboard entry and last one cycle.
  always @(negedge ClkPort) begin
    if (Reset) begin
      prev_a <= 1'b0;
      prev_b <= 1'b0;
    end else begin
      if (prev_a) checkOutput("ackA_pulse_width", {31'b0, ackA}, 32'd0);
      if (prev_b) checkOutput("ackB_pulse_width", {31'b0, ackB}, 32'd0);
      if (ackA || ackB) begin
        ack_seen++;
        if (ackA && ackB) begin
          n_cmp++;
          n_fail++;
          $display("[TB] FAIL dual_ack: got ackA=1 ackB=1 expected one ack");
        end else if (sb.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("[TB] FAIL unexpected_ack: got ackA=%0b ackB=%0b expected none", ackA, ackB);
        end else begin
          exp_t e;
          e = sb.pop_front();
          checkOutput("ack_owner_is_b", {31'b0, ackB}, {31'b0, e.is_b});
          checkOutput(ackB ? "bcdB_value" : "bcdA_value", {20'b0, (ackB ? bcdB : bcdA)}, {20'b0, e.val});
        end
      end
      prev_a <= ackA;
      prev_b <= ackB;
    end
  end

  initial begin
    applyStimulus(1'b0, 8'd0, 1'b0, 8'd0);
    Reset = 1'b1;
    idleCycles(3);
    checkOutput("reset_busy",  {31'b0, busy},  32'd0);
    checkOutput("reset_ackA",  {31'b0, ackA},  32'd0);
    checkOutput("reset_ackB",  {31'b0, ackB},  32'd0);
    checkOutput("reset_bcdA",  {20'b0, bcdA},  32'd0);
    checkOutput("reset_bcdB",  {20'b0, bcdB},  32'd0);
    checkOutput("reset_grant", {31'b0, grant}, 32'd0);
    Reset = 1'b0;
    idleCycles(1);

    // A alone with 255: latency and busy length.
    pushExp(1'b0, 12'h255);
    applyStimulus(1'b1, 8'd255, 1'b0, 8'd0);
    measureLatency("t1", 10, 9);
    applyStimulus(1'b0, 8'd255, 1'b0, 8'd0);
    checkOutput("t1_bcdB_untouched", {20'b0, bcdB}, 32'd0);
    idleCycles(2);

    // B with 0 then 9.
    pushExp(1'b1, 12'h000);
    applyStimulus(1'b0, 8'd0, 1'b1, 8'd0);
    waitAcks(1, 20, "t2a");
    applyStimulus(1'b0, 8'd0, 1'b0, 8'd0);
    checkOutput("t2_grant", {31'b0, grant}, 32'd1);
    idleCycles(2);
    pushExp(1'b1, 12'h009);
    applyStimulus(1'b0, 8'd0, 1'b1, 8'd9);
    waitAcks(1, 20, "t2b");
    applyStimulus(1'b0, 8'd0, 1'b0, 8'd9);
    idleCycles(3);

    // Both held continuously: ack masking alternates A, B, A.
    pushExp(1'b0, 12'h200);
    pushExp(1'b1, 12'h017);
    pushExp(1'b0, 12'h200);
    applyStimulus(1'b1, 8'd200, 1'b1, 8'd17);
    waitAcks(3, 60, "t4");
    applyStimulus(1'b0, 8'd200, 1'b0, 8'd17);
    idleCycles(2);
    checkOutput("t4_idle_after", {31'b0, busy}, 32'd0);

    // A alone (99), then simultaneous A=137 / B=42.
    pushExp(1'b0, 12'h099);
    applyStimulus(1'b1, 8'd99, 1'b0, 8'd0);
    waitAcks(1, 20, "t3a");
    applyStimulus(1'b0, 8'd99, 1'b0, 8'd0);
    idleCycles(2);
`ifdef BCD_ARB_RR_EN
    pushExp(1'b1, 12'h042);
    pushExp(1'b0, 12'h137);
`else
    pushExp(1'b0, 12'h137);
    pushExp(1'b1, 12'h042);
`endif
    applyStimulus(1'b1, 8'd137, 1'b1, 8'd42);
    waitAcks(2, 40, "t3b");
    applyStimulus(1'b0, 8'd137, 1'b0, 8'd42);
    idleCycles(3);

    // Operand change during SHIFT is ignored.
    pushExp(1'b0, 12'h128);
    applyStimulus(1'b1, 8'd128, 1'b0, 8'd0);
    idleCycles(4);
    applyStimulus(1'b1, 8'd5, 1'b0, 8'd0);
    waitAcks(1, 20, "t5");
    applyStimulus(1'b0, 8'd5, 1'b0, 8'd0);
    idleCycles(2);

    // Reset in the middle of SHIFT discards the conversion.
    pushExp(1'b0, 12'h077);
    applyStimulus(1'b1, 8'd77, 1'b0, 8'd0);
    idleCycles(5);
    Reset = 1'b1;
    #1;
    sb.delete();
    checkOutput("t6_reset_busy",  {31'b0, busy},  32'd0);
    checkOutput("t6_reset_ackA",  {31'b0, ackA},  32'd0);
    checkOutput("t6_reset_bcdA",  {20'b0, bcdA},  32'd0);
    checkOutput("t6_reset_grant", {31'b0, grant}, 32'd0);
    idleCycles(2);
    applyStimulus(1'b1, 8'd64, 1'b0, 8'd0);
    Reset = 1'b0;
    pushExp(1'b0, 12'h064);
    measureLatency("t6", 10, 9);
    applyStimulus(1'b0, 8'd64, 1'b0, 8'd0);
    idleCycles(4);
    checkOutput("scoreboard_drained", sb.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
